// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, bus FSM states and
// byte-strobe helpers.
package irq_ctrl_pkg;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t IRQ_ENA  = 3'd0;
    localparam reg_idx_t IRQ_PEND = 3'd1;
    localparam reg_idx_t IRQ_TYPE = 3'd2;
    localparam reg_idx_t IRQ_POL  = 3'd3;
    localparam reg_idx_t IRQ_STAT = 3'd4;
    localparam reg_idx_t IRQ_RAW  = 3'd5;

    typedef enum logic [0:0] {
        StIdle,
        StResp
    } bus_state_e;

    // Expand 4 byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] mask;
        mask = strb_mask(strb);
        return (old_val & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/irq_ctrl_line.sv
// One interrupt line: input capture (2-flop synchroniser when IRQ_CTRL_SYNC_EN is defined),
// polarity, edge detect and the pending bit.
module irq_ctrl_line
    import irq_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    input  logic type_i,   // 1 = edge, 0 = level
    input  logic pol_i,    // 1 = active-low / falling edge
    input  logic clr_i,    // W1C request, edge mode only
    output logic act_o,
    output logic pend_o
);

    logic in_q;
    logic act;
    logic act_d_q;
    logic set;
    logic pend_q;
    logic pend_d;

`ifdef IRQ_CTRL_SYNC_EN
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 1'b0;
            in_q   <= 1'b0;
        end else begin
            sync_q <= raw_i;
            in_q   <= sync_q;
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_q <= 1'b0;
        end else begin
            in_q <= raw_i;
        end
    end
`endif

    assign act = in_q ^ pol_i;
    assign set = act & ~act_d_q;

    // A fresh edge beats a simultaneous clear so no event is lost.
    always_comb begin
        pend_d = pend_q;
        if (type_i) begin
            pend_d = set | (pend_q & ~clr_i);
        end else begin
            pend_d = act;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            act_d_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            act_d_q <= act;
            pend_q  <= pend_d;
        end
    end

    assign act_o  = act;
    assign pend_o = pend_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller top: nmi slave decode, register file, per-line conditioning and the
// registered irq vector. Define IRQ_CTRL_SYNC_EN for asynchronous sources (adds one clk latency).
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned IRQ_NUM = 32,
    parameter logic [31:0] ENA_RST = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] irq_raw_i,
    input  logic        nmi_valid_i,
    input  logic [31:0] nmi_addr_i,
    input  logic [31:0] nmi_wdata_i,
    input  logic [3:0]  nmi_wstrb_i,
    output logic [31:0] nmi_rdata_o,
    output logic        nmi_ready_o,
    output logic [31:0] irq_o
);

    localparam logic [31:0] IRQ_MASK =
        (IRQ_NUM >= 32) ? 32'hFFFF_FFFF : ((32'd1 << IRQ_NUM) - 32'd1);

    bus_state_e  state_q, state_d;
    logic [31:0] enable_q, enable_d;
    logic [31:0] type_q, type_d;
    logic [31:0] pol_q, pol_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] irq_q, irq_d;
    logic [31:0] pend_clr;
    logic [31:0] pend;
    logic [31:0] act;
    logic [31:0] rd_val;
    logic        accept;
    logic        wr_en;
    reg_idx_t    idx;
    logic        unused_addr;

    assign unused_addr = ^{nmi_addr_i[31:5], nmi_addr_i[1:0]};

    assign idx    = nmi_addr_i[4:2];
    assign accept = (state_q == StIdle) && nmi_valid_i;
    assign wr_en  = accept && (nmi_wstrb_i != 4'b0000);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (nmi_valid_i) state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        enable_d = enable_q;
        type_d   = type_q;
        pol_d    = pol_q;
        pend_clr = '0;
        if (wr_en) begin
            case (idx)
                IRQ_ENA:  enable_d = apply_strb(enable_q, nmi_wdata_i, nmi_wstrb_i) & IRQ_MASK;
                IRQ_PEND: pend_clr = nmi_wdata_i & strb_mask(nmi_wstrb_i) & IRQ_MASK;
                IRQ_TYPE: type_d   = apply_strb(type_q, nmi_wdata_i, nmi_wstrb_i) & IRQ_MASK;
                IRQ_POL:  pol_d    = apply_strb(pol_q, nmi_wdata_i, nmi_wstrb_i) & IRQ_MASK;
                default:  ;
            endcase
        end
    end

    // Read value is captured at accept, so it reflects the state before any same-cycle write.
    always_comb begin
        rd_val = '0;
        case (idx)
            IRQ_ENA:  rd_val = enable_q;
            IRQ_PEND: rd_val = pend;
            IRQ_TYPE: rd_val = type_q;
            IRQ_POL:  rd_val = pol_q;
            IRQ_STAT: rd_val = pend & enable_q;
            IRQ_RAW:  rd_val = act;
            default:  rd_val = '0;
        endcase
        rdata_d = accept ? rd_val : '0;
        irq_d   = pend & enable_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            enable_q <= ENA_RST & IRQ_MASK;
            type_q   <= '0;
            pol_q    <= '0;
            rdata_q  <= '0;
            irq_q    <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            type_q   <= type_d;
            pol_q    <= pol_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_lines
        if (g < int'(IRQ_NUM)) begin : g_line
            irq_ctrl_line u_line (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .raw_i   (irq_raw_i[g]),
                .type_i  (type_q[g]),
                .pol_i   (pol_q[g]),
                .clr_i   (pend_clr[g]),
                .act_o   (act[g]),
                .pend_o  (pend[g])
            );
        end else begin : g_tie
            logic unused_raw;
            assign unused_raw = irq_raw_i[g];
            assign act[g]     = 1'b0;
            assign pend[g]    = 1'b0;
        end
    end

    assign nmi_ready_o = (state_q == StResp);
    assign nmi_rdata_o = rdata_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register vector table plus hand-written interrupt sequences.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    localparam logic [31:0] A_ENA  = 32'h00;
    localparam logic [31:0] A_PEND = 32'h04;
    localparam logic [31:0] A_TYPE = 32'h08;
    localparam logic [31:0] A_POL  = 32'h0C;
    localparam logic [31:0] A_STAT = 32'h10;
    localparam logic [31:0] A_RAW  = 32'h14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] irq_raw;
    logic        nmi_valid;
    logic [31:0] nmi_addr;
    logic [31:0] nmi_wdata;
    logic [3:0]  nmi_wstrb;
    logic [31:0] nmi_rdata;
    logic        nmi_ready;
    logic [31:0] irq;

    int checks = 0;
    int errors = 0;

    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    irq_ctrl #(
        .IRQ_NUM (32),
        .ENA_RST (32'h0)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .irq_raw_i   (irq_raw),
        .nmi_valid_i (nmi_valid),
        .nmi_addr_i  (nmi_addr),
        .nmi_wdata_i (nmi_wdata),
        .nmi_wstrb_i (nmi_wstrb),
        .nmi_rdata_o (nmi_rdata),
        .nmi_ready_o (nmi_ready),
        .irq_o       (irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where ready is seen.
    task automatic bus(input string nm, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic chk, input logic [31:0] exp);
        int          n;
        logic [32:0] ent;
        sb_q.push_back({chk, exp});
        nmi_valid = 1'b1;
        nmi_addr  = addr;
        nmi_wdata = wdata;
        nmi_wstrb = strb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!nmi_ready && n < 10);
        ent = sb_q.pop_front();
        if (!nmi_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: ready timeout after %0d cycles", nm, n);
        end else if (ent[32]) begin
            check(nm, nmi_rdata, ent[31:0]);
        end
        nmi_valid = 1'b0;
        nmi_wstrb = 4'b0000;
    endtask

    task automatic wr(input string nm, input logic [31:0] addr, input logic [31:0] data);
        bus(nm, addr, data, 4'hF, 1'b0, 32'h0);
    endtask

    task automatic rd(input string nm, input logic [31:0] addr, input logic [31:0] exp);
        bus(nm, addr, 32'h0, 4'h0, 1'b1, exp);
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{A_ENA,        32'h0,         4'h0, 1'b1, 32'h0};
        vecs[1]  = '{A_PEND,       32'h0,         4'h0, 1'b1, 32'h0};
        vecs[2]  = '{A_STAT,       32'h0,         4'h0, 1'b1, 32'h0};
        vecs[3]  = '{A_ENA,        32'hFFFF_FFFF, 4'b0010, 1'b0, 32'h0};
        vecs[4]  = '{A_ENA,        32'h0,         4'h0, 1'b1, 32'h0000_FF00};
        vecs[5]  = '{A_TYPE,       32'h1234_5678, 4'hF, 1'b0, 32'h0};
        vecs[6]  = '{A_TYPE,       32'h0,         4'h0, 1'b1, 32'h1234_5678};
        vecs[7]  = '{A_TYPE,       32'hFFFF_FFFF, 4'b0101, 1'b0, 32'h0};
        vecs[8]  = '{32'hABC0_0008, 32'h0,        4'h0, 1'b1, 32'h12FF_56FF};
        vecs[9]  = '{A_POL,        32'hA5A5_FFFF, 4'b1100, 1'b0, 32'h0};
        vecs[10] = '{A_POL,        32'h0,         4'h0, 1'b1, 32'hA5A5_0000};
        vecs[11] = '{A_RAW,        32'h0,         4'h0, 1'b1, 32'hA5A5_0000};
        vecs[12] = '{32'h18,       32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
        vecs[13] = '{32'h18,       32'h0,         4'h0, 1'b1, 32'h0};
        vecs[14] = '{32'h1C,       32'h0,         4'h0, 1'b1, 32'h0};
        vecs[15] = '{A_TYPE,       32'h0,         4'hF, 1'b0, 32'h0};
        vecs[16] = '{A_POL,        32'h0,         4'hF, 1'b0, 32'h0};
        vecs[17] = '{A_ENA,        32'h0,         4'hF, 1'b0, 32'h0};
        vecs[18] = '{A_ENA,        32'h0,         4'h0, 1'b1, 32'h0};

        rst_n     = 1'b0;
        irq_raw   = '0;
        nmi_valid = 1'b0;
        nmi_addr  = '0;
        nmi_wdata = '0;
        nmi_wstrb = '0;

        cycles(3);
        check("rst_irq", irq, 32'h0);
        check("rst_ready", {31'b0, nmi_ready}, 32'h0);
        check("rst_rdata", nmi_rdata, 32'h0);
        rst_n = 1'b1;
        cycles(3);
        check("idle_ready", {31'b0, nmi_ready}, 32'h0);

        for (int i = 0; i < 19; i++) begin
            bus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                vecs[i].chk, vecs[i].exp);
        end
        cycles(LAT);
        check("clean_irq", irq, 32'h0);
        rd("clean_pend", A_PEND, 32'h0);

        // Edge mode on line 5.
        wr("edge_type", A_TYPE, 32'h20);
        wr("edge_ena", A_ENA, 32'h20);
        cycles(1);
        irq_raw[5] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) irq_raw[5] = 1'b0;
            check($sformatf("edge_lat%0d", k), {31'b0, irq[5]}, {31'b0, k == LAT});
        end
        cycles(3);
        check("edge_hold", irq, 32'h20);
        wr("edge_w1c", A_PEND, 32'h20);
        check("edge_w1c_next", irq, 32'h20);
        @(negedge clk);
        check("edge_w1c_clr", irq, 32'h0);

        // Level mode, active-low on line 9.
        wr("lvl_ena", A_ENA, 32'h220);
        wr("lvl_pol", A_POL, 32'h200);
        cycles(LAT);
        check("lvl_set", irq, 32'h200);
        wr("lvl_w1c", A_PEND, 32'h200);
        rd("lvl_pend", A_PEND, 32'h200);
        check("lvl_w1c_ign", irq, 32'h200);
        irq_raw[9] = 1'b1;
        cycles(LAT);
        check("lvl_clr", irq, 32'h0);

        // Masking on line 7.
        wr("mask_pol", A_POL, 32'h280);
        cycles(LAT);
        check("mask_irq", irq, 32'h0);
        rd("mask_stat", A_STAT, 32'h0);
        rd("mask_pend", A_PEND, 32'h80);
        wr("mask_ena", A_ENA, 32'h2A0);
        @(negedge clk);
        check("mask_unmask", irq, 32'h80);

        // Edge on line 3 coinciding with its W1C.
        wr("col_type", A_TYPE, 32'h28);
        wr("col_ena", A_ENA, 32'h2A8);
        irq_raw[3] = 1'b1;
        @(negedge clk);
        irq_raw[3] = 1'b0;
        cycles(LAT);
        check("col_first", irq, 32'h88);
        irq_raw[3] = 1'b1;
        @(negedge clk);
        irq_raw[3] = 1'b0;
        wr("col_w1c", A_PEND, 32'h8);
        rd("col_pend", A_PEND, 32'h88);
        wr("col_w1c2", A_PEND, 32'h8);
        rd("col_pend2", A_PEND, 32'h80);

        // Reset while a write is in flight.
        nmi_valid = 1'b1;
        nmi_addr  = A_ENA;
        nmi_wdata = 32'hFFFF_FFFF;
        nmi_wstrb = 4'hF;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", {31'b0, nmi_ready}, 32'h0);
        check("mid_rst_rdata", nmi_rdata, 32'h0);
        nmi_valid = 1'b0;
        nmi_wstrb = 4'h0;
        irq_raw   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        check("post_rst_ready", {31'b0, nmi_ready}, 32'h0);
        rd("post_rst_ena", A_ENA, 32'h0);
        rd("post_rst_type", A_TYPE, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
